l2_line_responder: RTL and testbench



---
 rtl/lc3b_types.sv | 8 +
 rtl/line_fill_buffer.sv | 39 +++
 rtl/l2_line_responder.sv | 118 +++++++++++
 tb/tb_l2_line_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared word, line and tag types for the cache line-fill path.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_tag;

endpackage

// File: rtl/line_fill_buffer.sv
// One-entry line buffer: eight individually writable words plus tag and valid.
module line_fill_buffer
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic [11:0]  tag_i,
  input  logic         we_i,
  input  logic [2:0]   widx_i,
  input  logic [15:0]  wdata_i,
  input  logic         set_valid_i,
  output logic [127:0] line_o,
  output logic         valid_o,
  output logic [11:0]  tag_o
);

  logic [7:0][15:0] words_q;
  logic             valid_q;
  lc3b_line_tag     tag_q;

  // Starting a fill wipes the old line so a partial fill can never look complete.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      words_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (we_i) words_q[widx_i] <= wdata_i;
      if (set_valid_i) valid_q <= 1'b1;
    end
    if (reset) tag_q <= '0;
    else if (clear_i) tag_q <= tag_i;
  end

  assign line_o  = words_q;
  assign valid_o = valid_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/l2_line_responder.sv
// Line-fill responder: assembles a 128-bit line from eight 16-bit memory reads
// and answers repeat requests for the last filled line from a one-entry buffer.
//
//   state   | meaning
//   S_IDLE  | waiting for L2_read; hit -> S_RESP, miss -> S_FETCH
//   S_FETCH | reading word k from memory until word 7 returns
//   S_RESP  | one-cycle L2_resp pulse with the buffered line
module l2_line_responder
  import lc3b_types::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int OFFSET_BITS    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         L2_read,
  input  logic [15:0]  L2_address,
  output logic         L2_resp,
  output logic [127:0] L2_rdata,
  output logic         pmem_read,
  output logic [15:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [15:0]  pmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_e;

  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_LINE - 1);

  state_e       state_q;
  logic [2:0]   k_q;
  logic         hold_off_q;
  logic         l2_resp_q;
  logic         pmem_read_q;
  lc3b_word     pmem_address_q;

  lc3b_line_tag req_tag;
  lc3b_line_tag buf_tag;
  logic         buf_valid;
  logic         hit;
  logic         fill_start;
  logic         word_we;
  logic         last_word;
  logic         unused_addr_bits;

  assign req_tag          = L2_address[15:OFFSET_BITS];
  assign unused_addr_bits = ^L2_address[OFFSET_BITS-1:0];
  assign hit              = buf_valid && (buf_tag == req_tag);
  assign fill_start       = (state_q == S_IDLE) && !hold_off_q && L2_read && !hit;
  assign word_we          = (state_q == S_FETCH) && pmem_resp;
  assign last_word        = (k_q == LAST_WORD);

  line_fill_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (fill_start),
    .tag_i       (req_tag),
    .we_i        (word_we),
    .widx_i      (k_q),
    .wdata_i     (pmem_rdata),
    .set_valid_i (word_we && last_word),
    .line_o      (L2_rdata),
    .valid_o     (buf_valid),
    .tag_o       (buf_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      hold_off_q     <= 1'b0;
      l2_resp_q      <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_off_q <= 1'b0;
          if (!hold_off_q && L2_read) begin
            if (hit) begin
              state_q   <= S_RESP;
              l2_resp_q <= 1'b1;
            end else begin
              state_q        <= S_FETCH;
              k_q            <= '0;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag, 3'd0, 1'b0};
            end
          end
        end
        S_FETCH: begin
          if (pmem_resp) begin
            if (last_word) begin
              state_q     <= S_RESP;
              pmem_read_q <= 1'b0;
              l2_resp_q   <= 1'b1;
            end else begin
              k_q            <= k_q + 3'd1;
              pmem_address_q <= {buf_tag, k_q + 3'd1, 1'b0};
            end
          end
        end
        S_RESP: begin
          // Block the very next IDLE cycle so a still-high L2_read is not re-served.
          state_q    <= S_IDLE;
          l2_resp_q  <= 1'b0;
          hold_off_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign L2_resp      = l2_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_address = pmem_address_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: latency-programmable memory responder plus a
// one-entry line model predicting hit/miss, latency, data and fetch addresses.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         L2_read = 1'b0;
  logic [15:0]  L2_address = '0;
  logic         L2_resp;
  logic [127:0] L2_rdata;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_resp = 1'b0;
  logic [15:0]  pmem_rdata = '0;

  l2_line_responder dut (
    .clk          (clk),
    .reset        (reset),
    .L2_read      (L2_read),
    .L2_address   (L2_address),
    .L2_resp      (L2_resp),
    .L2_rdata     (L2_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  int lat_cnt = 0;
  int resp_cnt = 0;
  int pr_cnt = 0;
  bit stray_pulse = 0;
  logic [15:0] mem [32768];
  logic [15:0] pmem_log [$];

  bit           m_valid = 0;
  logic [11:0]  m_tag = '0;
  logic [127:0] m_line = '0;

  always @(posedge clk) cyc++;

  // Memory model: answers each word request in its lat-th cycle.
  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (stray_pulse) begin
      pmem_resp   = 1'b1;
      pmem_rdata  = 16'hDEAD;
      stray_pulse = 0;
      lat_cnt     = 0;
    end else if (pmem_read) begin
      lat_cnt++;
      if (lat_cnt >= lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem[pmem_address[15:1]];
        pmem_log.push_back(pmem_address);
        lat_cnt    = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (L2_resp) resp_cnt++;
    if (pmem_read) pr_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_request(input logic [15:0] addr, input bit hold_extra, input string name);
    logic [11:0]  tg;
    logic [127:0] exp_line;
    logic [15:0]  exp_addr;
    bit           hit;
    bit           got;
    bit           bad;
    int           exp_lat;
    int           c0;
    int           n;
    int           pr_at_resp;
    tg      = addr[15:4];
    hit     = m_valid && (m_tag == tg);
    exp_lat = hit ? 1 : 8 * lat + 1;
    for (int k = 0; k < 8; k++)
      exp_line[16*k +: 16] = hit ? m_line[16*k +: 16] : mem[{tg, 3'(k)}];
    pmem_log.delete();
    resp_cnt   = 0;
    pr_cnt     = 0;
    L2_read    = 1'b1;
    L2_address = addr;
    c0         = cyc;
    got = 0;
    n   = 0;
    while (!got && n < 400) begin
      step();
      n++;
      if (L2_resp) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s resp_timeout: no L2_resp within %0d cycles, expected at %0d", name, n, exp_lat);
      L2_read = 1'b0;
      return;
    end
    checks++;
    if ((cyc - c0) !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc - c0, exp_lat);
    end
    checks++;
    if (L2_rdata !== exp_line) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", name, L2_rdata, exp_line);
    end
    checks++;
    if (hit) begin
      if (pr_cnt !== 0) begin
        errors++;
        $display("FAIL %s hit_pmem_read: got %0d read cycles expected 0", name, pr_cnt);
      end
    end else begin
      bad = (pmem_log.size() != 8);
      if (bad) begin
        $display("FAIL %s fetch_count: got %0d words expected 8", name, pmem_log.size());
      end else begin
        for (int k = 0; k < 8; k++) begin
          exp_addr = {tg, 3'(k), 1'b0};
          if (!bad && pmem_log[k] !== exp_addr) begin
            bad = 1;
            $display("FAIL %s fetch_addr[%0d]: got %h expected %h", name, k, pmem_log[k], exp_addr);
          end
        end
      end
      if (bad) errors++;
    end
    pr_at_resp = pr_cnt;
    if (hold_extra) step();
    L2_read = 1'b0;
    repeat (3) step();
    checks++;
    if (resp_cnt !== 1) begin
      errors++;
      $display("FAIL %s resp_count: got %0d expected 1", name, resp_cnt);
    end
    checks++;
    if (pr_cnt !== pr_at_resp) begin
      errors++;
      $display("FAIL %s read_after_resp: got %0d extra read cycles expected 0", name, pr_cnt - pr_at_resp);
    end
    m_valid = 1;
    m_tag   = tg;
    m_line  = exp_line;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    L2_read = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (L2_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got resp=%b read=%b expected 0 0", L2_resp, pmem_read);
    end
    checks++;
    if (pmem_address !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0000", pmem_address);
    end
    checks++;
    if (L2_rdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", L2_rdata);
    end
    stray_pulse = 1;
    pr_cnt   = 0;
    resp_cnt = 0;
    repeat (3) step();
    checks++;
    if (pr_cnt !== 0 || resp_cnt !== 0 || L2_rdata !== 128'h0) begin
      errors++;
      $display("FAIL stray_resp: got reads=%0d resps=%0d rdata=%h expected 0 0 0", pr_cnt, resp_cnt, L2_rdata);
    end
    m_valid = 0;
  endtask

  task automatic test_cold_miss();
    lat = 2;
    do_request(16'h1234, 0, "cold_miss");
    checks++;
    if (L2_rdata !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      errors++;
      $display("FAIL cold_line_const: got %h expected a007a006a005a004a003a002a001a000", L2_rdata);
    end
  endtask

  task automatic test_repeat_hit();
    lat = 3;
    do_request(16'h123C, 0, "repeat_hit");
  endtask

  task automatic test_new_line();
    lat = 1;
    do_request(16'h2000, 0, "new_line");
    do_request(16'h1230, 0, "old_line_miss");
  endtask

  task automatic test_reset_mid_fill();
    int n;
    lat = 2;
    do_request(16'h2008, 0, "prefill_2000");
    pmem_log.delete();
    resp_cnt   = 0;
    L2_read    = 1'b1;
    L2_address = 16'h1230;
    n = 0;
    while (pmem_log.size() < 3 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (pmem_log.size() < 3) begin
      errors++;
      $display("FAIL midfill_timeout: got %0d words expected 3", pmem_log.size());
    end
    reset   = 1'b1;
    L2_read = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (pmem_read !== 1'b0 || L2_resp !== 1'b0 || resp_cnt !== 0) begin
      errors++;
      $display("FAIL midfill_reset: got read=%b resp=%b resps=%0d expected 0 0 0", pmem_read, L2_resp, resp_cnt);
    end
    m_valid = 0;
    do_request(16'h1230, 0, "refill_after_reset");
  endtask

  task automatic test_hold_extra();
    lat = 2;
    do_request(16'h1238, 1, "hold_extra_hit");
    do_request(16'h4440, 1, "hold_extra_miss");
  endtask

  task automatic test_reset_with_read();
    pr_cnt     = 0;
    resp_cnt   = 0;
    reset      = 1'b1;
    L2_read    = 1'b1;
    L2_address = 16'h5550;
    step();
    reset   = 1'b0;
    L2_read = 1'b0;
    repeat (3) step();
    checks++;
    if (pr_cnt !== 0 || resp_cnt !== 0) begin
      errors++;
      $display("FAIL reset_with_read: got reads=%0d resps=%0d expected 0 0", pr_cnt, resp_cnt);
    end
    m_valid = 0;
  endtask

  task automatic test_random();
    logic [11:0] tags [3];
    logic [15:0] addr;
    tags[0] = 12'h123;
    tags[1] = 12'h200;
    for (int i = 0; i < 30; i++) begin
      tags[2] = 12'($urandom);
      addr = {tags[$urandom_range(0, 2)], 4'($urandom)};
      lat  = $urandom_range(1, 4);
      do_request(addr, bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 8; k++) mem[15'h1230 >> 1 | 15'(k)] = 16'hA000 + 16'(k);
    test_reset();
    test_cold_miss();
    test_repeat_hit();
    test_new_line();
    test_reset_mid_fill();
    test_hold_extra();
    test_reset_with_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
